// File: rtl/term_char_writer.sv
// Terminal text engine feeding the 64x32 character buffer write port.
// Interprets CR/LF/BS/FF, writes printable bytes, scrolls by row offset.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rx_data/valid/ready   incoming byte handshake (ready only in IDLE)
//   wr_en/addr/data       buffer write port, addr = {phys_row, col}
//   cursor_col/row        logical cursor (row 0 = top of screen)
//   scroll_row            physical buffer row shown at screen top
module term_char_writer #(
    parameter int         COLS = 64,
    parameter int         ROWS = 32,
    parameter logic [7:0] FILL = 8'h20
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic                              rx_ready,
    output logic                              wr_en,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] wr_addr,
    output logic [7:0]                        wr_data,
    output logic [$clog2(COLS)-1:0]           cursor_col,
    output logic [$clog2(ROWS)-1:0]           cursor_row,
    output logic [$clog2(ROWS)-1:0]           scroll_row
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = RW + CW;

    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_SCREEN
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_addr;
    logic          clr_done;

    logic          accept;
    logic          printable;
    logic          is_cr;
    logic          is_lf;
    logic          is_bs;
    logic          is_ff;
    logic          clr_last;
    logic [RW-1:0] phys_row;

    assign accept    = rx_valid && rx_ready;
    assign printable = (rx_data >= 8'h20) && (rx_data != 8'h7F);
    assign is_cr     = (rx_data == 8'h0D);
    assign is_lf     = (rx_data == 8'h0A);
    assign is_bs     = (rx_data == 8'h08);
    assign is_ff     = (rx_data == 8'h0C);
    assign phys_row  = cursor_row + scroll_row;

    // Line clear ends at the last column; screen clear at the last cell.
    assign clr_last = (state == CLR_SCREEN) ? (&clr_addr)
                                            : (&clr_addr[CW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cursor_col <= '0;
            cursor_row <= '0;
            scroll_row <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= FILL;
            rx_ready   <= 1'b1;
            clr_addr   <= '0;
            clr_done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    if (accept) begin
                        unique case (1'b1)
                            printable: begin
                                wr_en      <= 1'b1;
                                wr_addr    <= {phys_row, cursor_col};
                                wr_data    <= rx_data;
                                cursor_col <= cursor_col + 1'b1;
                                if (cursor_col == COL_MAX) begin
                                    if (cursor_row != ROW_MAX) begin
                                        cursor_row <= cursor_row + 1'b1;
                                    end else begin
                                        // Char write goes out first; the
                                        // clear starts on the next cycle.
                                        scroll_row <= scroll_row + 1'b1;
                                        clr_addr   <= {scroll_row, {CW{1'b0}}};
                                        clr_done   <= 1'b0;
                                        rx_ready   <= 1'b0;
                                        state      <= CLR_LINE;
                                    end
                                end
                            end
                            is_cr: cursor_col <= '0;
                            is_lf: begin
                                if (cursor_row != ROW_MAX) begin
                                    cursor_row <= cursor_row + 1'b1;
                                end else begin
                                    // First clear write issued right away
                                    // so the busy window is exactly COLS.
                                    scroll_row <= scroll_row + 1'b1;
                                    wr_en      <= 1'b1;
                                    wr_addr    <= {scroll_row, {CW{1'b0}}};
                                    wr_data    <= FILL;
                                    clr_addr   <= {scroll_row, CW'(1)};
                                    clr_done   <= 1'b0;
                                    rx_ready   <= 1'b0;
                                    state      <= CLR_LINE;
                                end
                            end
                            is_bs: begin
                                if (cursor_col != '0)
                                    cursor_col <= cursor_col - 1'b1;
                            end
                            is_ff: begin
                                cursor_col <= '0;
                                cursor_row <= '0;
                                scroll_row <= '0;
                                wr_en      <= 1'b1;
                                wr_addr    <= '0;
                                wr_data    <= FILL;
                                clr_addr   <= AW'(1);
                                clr_done   <= 1'b0;
                                rx_ready   <= 1'b0;
                                state      <= CLR_SCREEN;
                            end
                            default: ;
                        endcase
                    end
                end
                CLR_LINE, CLR_SCREEN: begin
                    if (clr_done) begin
                        wr_en    <= 1'b0;
                        rx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wr_en    <= 1'b1;
                        wr_addr  <= clr_addr;
                        wr_data  <= FILL;
                        clr_addr <= clr_addr + 1'b1;
                        clr_done <= clr_last;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_term_char_writer.sv
// Self-checking bench for term_char_writer: vector table, corner
// sequences and randomized bytes against a behavioural screen model.
module tb_term_char_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [4:0]  scroll_row;

    term_char_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .scroll_row (scroll_row)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  m_col, m_row, m_scr;
    int  n_wr = 0;
    int  last_addr = 0;
    int  last_data = 0;
    bit  mon_on = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Screen model: cursor, scroll offset and the expected write stream.
    task automatic m_newline();
        int old;
        if (m_row < 31) begin
            m_row++;
        end else begin
            old   = m_scr;
            m_scr = (m_scr + 1) % 32;
            for (int c = 0; c < 64; c++)
                exp_q.push_back('{old * 64 + c, 32'h20});
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if ((b >= 8'h20) && (b != 8'h7F)) begin
            exp_q.push_back('{((m_row + m_scr) % 32) * 64 + m_col, int'(b)});
            m_col++;
            if (m_col == 64) begin
                m_col = 0;
                m_newline();
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_newline();
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            for (int a = 0; a < 2048; a++)
                exp_q.push_back('{a, 32'h20});
            m_col = 0;
            m_row = 0;
            m_scr = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && rst_n === 1'b1 && wr_en === 1'b1) begin
            n_wr++;
            last_addr = int'(wr_addr);
            last_data = int'(wr_data);
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_write: addr %0h data %0h, none required",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(wr_addr), e.addr);
                check("write_data", 32'(wr_data), e.data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},    32'(wr_en), 0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 1);
        check({tag, "_wr_addr"},  32'(wr_addr), 0);
        check({tag, "_wr_data"},  32'(wr_data), 32'h20);
        check({tag, "_col"},      32'(cursor_col), 0);
        check({tag, "_row"},      32'(cursor_row), 0);
        check({tag, "_scroll"},   32'(scroll_row), 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        m_scr = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Offers one byte, waits for acceptance and for the writer to be
    // ready again; low_cyc counts the busy cycles after acceptance.
    task automatic send(input logic [7:0] b, output int low_cyc);
        int t;
        model_byte(b);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 5000) begin
                errors++;
                checks++;
                $display("FAIL accept_timeout: byte %0h not taken, 5000 cycle limit", b);
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        low_cyc  = 0;
        forever begin
            @(negedge clk);
            if (rx_ready === 1'b1) break;
            low_cyc++;
            if (low_cyc > 5000) begin
                errors++;
                checks++;
                $display("FAIL ready_timeout: byte %0h busy, 5000 cycle limit", b);
                break;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_col"},    32'(cursor_col), m_col);
        check({tag, "_row"},    32'(cursor_row), m_row);
        check({tag, "_scroll"}, 32'(scroll_row), m_scr);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0] b;
        int col, row, scr, nwr, addr, data;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int lc, n0, r, ffs;
        logic [7:0] b;

        tbl[0]  = '{8'h48, 1, 0, 0, 1, 'h000, 'h48};
        tbl[1]  = '{8'h69, 2, 0, 0, 1, 'h001, 'h69};
        tbl[2]  = '{8'h41, 3, 0, 0, 1, 'h002, 'h41};
        tbl[3]  = '{8'h41, 4, 0, 0, 1, 'h003, 'h41};
        tbl[4]  = '{8'h41, 5, 0, 0, 1, 'h004, 'h41};
        tbl[5]  = '{8'h0D, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{8'h08, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{8'h07, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{8'h0A, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{8'h7F, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{8'h80, 1, 1, 0, 1, 'h040, 'h80};
        tbl[11] = '{8'h08, 0, 1, 0, 0, 0, 0};
        tbl[12] = '{8'hFF, 1, 1, 0, 1, 'h040, 'hFF};

        // Vector table from reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            n0 = n_wr;
            send(tbl[i].b, lc);
            check("tbl_col",    32'(cursor_col), tbl[i].col);
            check("tbl_row",    32'(cursor_row), tbl[i].row);
            check("tbl_scroll", 32'(scroll_row), tbl[i].scr);
            check("tbl_nwr",    n_wr - n0, tbl[i].nwr);
            check("tbl_ready",  32'(rx_ready), 1);
            if (tbl[i].nwr > 0) begin
                check("tbl_addr", last_addr, tbl[i].addr);
                check("tbl_data", last_data, tbl[i].data);
            end
        end

        // Full line wraps to row 1 without any clear.
        do_reset();
        n0 = n_wr;
        for (int i = 0; i < 64; i++) send(8'h41, lc);
        check("wrap_last_addr", last_addr, 'h03F);
        check("wrap_nwr", n_wr - n0, 64);
        check_model("wrap");
        check("wrap_col_abs", 32'(cursor_col), 0);
        check("wrap_row_abs", 32'(cursor_row), 1);

        // LF at the bottom scrolls and clears physical row 0.
        do_reset();
        for (int i = 0; i < 31; i++) send(8'h0A, lc);
        check("lf31_row", 32'(cursor_row), 31);
        n0 = n_wr;
        send(8'h0A, lc);
        check("scroll_busy", lc, 64);
        check("scroll_nwr", n_wr - n0, 64);
        check("scroll_row_abs", 32'(scroll_row), 1);
        check_model("scroll");
        send(8'h5A, lc);
        check("z_addr", last_addr, 'h000);
        check("z_data", last_data, 'h5A);
        check_model("z");

        // Wrap at col 63 on the bottom row: char then 64 clears.
        do_reset();
        for (int i = 0; i < 31; i++) send(8'h0A, lc);
        for (int i = 0; i < 63; i++) send(8'h2E, lc);
        n0 = n_wr;
        send(8'h51, lc);
        check("wrap_scroll_nwr", n_wr - n0, 65);
        check_model("wrap_scroll");

        // FF with 'X' held on the input through the whole clear.
        send(8'h62, lc);
        model_byte(8'h0C);
        rx_data  = 8'h0C;
        rx_valid = 1'b1;
        n0 = n_wr;
        @(posedge clk);
        #1;
        rx_data = 8'h58;
        model_byte(8'h58);
        @(negedge clk);
        check("ff_col",    32'(cursor_col), 0);
        check("ff_row",    32'(cursor_row), 0);
        check("ff_scroll", 32'(scroll_row), 0);
        lc = 0;
        while (rx_ready !== 1'b1 && lc < 5000) begin
            lc++;
            @(negedge clk);
        end
        check("ff_busy", lc, 2048);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        #1;
        check("ff_nwr", n_wr - n0, 2049);
        check("ff_x_addr", last_addr, 0);
        check("ff_x_data", last_data, 'h58);
        check_model("ff");

        // Reset asserted in the middle of a screen clear.
        do_reset();
        mon_on   = 1'b0;
        rx_data  = 8'h0C;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (1001) @(negedge clk);
        check("mid_ff_wr_en", 32'(wr_en), 1);
        check("mid_ff_addr",  32'(wr_addr), 1000);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("after_abort");
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        m_scr = 0;
        mon_on = 1'b1;
        send(8'h58, lc);
        check("abort_x_addr", last_addr, 0);
        check_model("abort_x");

        // Randomized byte stream against the screen model.
        do_reset();
        ffs = 0;
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                b = 8'($urandom_range(32, 255));
            end else if (r < 80) begin
                b = 8'h0A;
            end else if (r < 87) begin
                b = 8'h0D;
            end else if (r < 93) begin
                b = 8'h08;
            end else if (r < 97) begin
                b = 8'($urandom_range(0, 31));
            end else if (r < 99 || ffs >= 3) begin
                b = 8'h7F;
            end else begin
                b = 8'h0C;
                ffs++;
            end
            send(b, lc);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/term_char_writer.md
Name: term_char_writer

Overview:
Terminal text engine that sits directly upstream of the 64x32 monochrome character buffer write port. It consumes received serial bytes and interprets a minimal control-code set (CR, LF, BS, FF). Printable bytes are written as character codes at the cursor position. It provides hardware scrolling through a row-offset output, which the display read side adds to its row address.

Parameters:
COLS, 64, characters per row (power of two; col width CW = log2(COLS) = 6)
ROWS, 32, rows on screen (power of two; row width RW = log2(ROWS) = 5)
FILL, 8'h20, byte written when clearing cells

Ports:
clk  in  1  system clock (same clock as the buffer write port)
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  writer can accept a byte this cycle
wr_en  out  1  buffer write enable (drives cea)
wr_addr  out  11  buffer address {phys_row[4:0], col[5:0]} (drives ada)
wr_data  out  8  buffer write data (drives din)
cursor_col  out  6  logical cursor column
cursor_row  out  5  logical cursor row (0 = top of screen)
scroll_row  out  5  physical buffer row shown at screen top

Behaviour:
- Reset (async, rst_n=0): state IDLE, cursor 0/0, scroll_row=0, wr_en=0, wr_addr=0, wr_data=FILL, rx_ready=1. Buffer contents are not touched by reset.
- Handshake: a byte is accepted on a clock edge where rx_valid && rx_ready. rx_ready=1 only in IDLE. rx_valid while not ready is ignored; the upstream must hold it.
- phys_row = (cursor_row + scroll_row) mod ROWS.
- States: IDLE, CLR_LINE, CLR_SCREEN.
- IDLE, printable byte (0x20..0x7E or 0x80..0xFF):
  - Next cycle: wr_en=1, wr_addr={phys_row, cursor_col}, wr_data=byte.
  - Latency 1 cycle. Then cursor_col++.
  - If cursor_col was COLS-1: cursor_col=0 and a NEWLINE is performed.
- 0x0D CR: cursor_col=0. No write.
- 0x0A LF: NEWLINE. cursor_col is unchanged.
- 0x08 BS: if cursor_col>0, cursor_col--. No erase. At col 0, no effect (no reverse line wrap).
- 0x0C FF: enter CLR_SCREEN. Cursor is set to 0/0 and scroll_row to 0.
- Any other byte (0x00..0x1F other than the above, and 0x7F): consumed and discarded. State does not change.
- NEWLINE:
  - If cursor_row<ROWS-1: cursor_row++ and stay in IDLE.
  - Otherwise scroll: old = scroll_row; scroll_row = old+1 (wraps 31 -> 0); cursor_row stays ROWS-1; enter CLR_LINE targeting physical row old, which is now the bottom line.
- CLR_LINE:
  - Writes FILL to {old, c} for c = 0..COLS-1, one per cycle, wr_en=1.
  - Exactly COLS cycles, then back to IDLE.
  - Wrap at column 63 combined with scroll: the character write occurs first, then 64 clear cycles.
  - rx_ready=1 again in the cycle after the last clear write.
- CLR_SCREEN:
  - Writes FILL to addresses 0..2047 sequentially, wr_en=1 every cycle, then IDLE.
  - Exactly 2048 cycles, all with rx_ready=0.
- wr_en is 0 in IDLE except the single write cycle following a printable byte.
- Reset asserted mid-CLR_LINE or mid-CLR_SCREEN aborts immediately. The partially cleared buffer stays as is; all registers return to reset values.
- Arithmetic: col and row counters are CW/RW bits wide with natural modulo wrap. Address concatenation is {row, col}, 11 bits.

Test Plan:
- Reset, send 'H'(0x48) then 'i'(0x69) -> wr_en pulses with addr 0x000 data 0x48 then addr 0x001 data 0x69; cursor_col=2, cursor_row=0.
- Send 64 x 'A' from reset -> last write addr 0x03F; cursor_col=0, cursor_row=1; no clear cycles occur.
- Cursor at col 5, send 0x0D then 0x08 -> cursor_col=0 then stays 0; no writes. Send 0x07 -> discarded, rx_ready stays 1.
- Send 31 LFs (cursor_row=31), then LF -> scroll_row=1; 64 writes of 0x20 to addr 0x000..0x03F; rx_ready low for exactly 64 cycles. Then send 'Z' -> write at addr {0,col} = 0x000.
- Send 0x0C -> 2048 consecutive writes of 0x20 at addr 0..2047; cursor 0/0; scroll_row=0; rx_ready=0 throughout. Hold rx_valid with 'X' during the clear -> 'X' is accepted only after the clear and written to addr 0x000.
- Assert rst_n=0 at clear cycle 1000 of FF -> wr_en=0 immediately (asynchronous); rx_ready=1 and all outputs at reset values after release.
